layer_compositor: RTL and testbench
===================================

# layer_compositor

Parametrised, pipelined pixel compositor for the VGA path. It receives per-layer hit flags and palette indices from the sprite address generators (duck, dog, score, grass, …) and resolves them through a writable shared palette with a transparency key. It applies fixed layer priority, cursor override with shot-flash timing, and screen-mode fills, then drives registered VGA_R/G/B. It sits between the sprite ROM/address logic and the VGA controller, and replaces the combinational colour mapper.

## Interface
Parameters:
- NUM_LAYERS, 4, number of sprite layers; layer 0 has the highest priority
- IDX_W, 4, palette index width; the palette holds 2**IDX_W entries of 24 bits
- KEY_COLOR, 24'hF442EE, palette value treated as transparent
- BG_COLOR, 24'h0000F0, game-mode background
- TITLE_COLOR, 24'h00F0F0, title-mode fill
- FLASH_FRAMES, 4, frames the cursor stays black after a counted shot (1..255)
- MAX_SHOTS, 3, counted shots per round (1..255)

Ports:
- Clk  in  1  pixel clock
- Reset_n  in  1  asynchronous, active-low reset
- pix_valid  in  1  qualifies this cycle's pixel inputs
- frame_start  in  1  one-cycle pulse at the start of each frame
- mode  in  2  screen mode: 00 title, 01 game, 10/11 blackout
- layer_en  in  NUM_LAYERS  per-layer hit; bit i belongs to layer i
- layer_idx  in  NUM_LAYERS*IDX_W  packed indices; layer i is at [i*IDX_W +: IDX_W]
- is_cursor  in  1  pixel is inside the crosshair
- shot  in  1  one-cycle trigger pulse
- rearm  in  1  one-cycle pulse that clears the shot counter (new round)
- pal_we  in  1  palette write enable
- pal_waddr  in  IDX_W  palette write address
- pal_wdata  in  24  palette write data {R,G,B}
- VGA_R, VGA_G, VGA_B  out  8 each  registered colour
- out_valid  out  1  pix_valid delayed to align with the RGB outputs
- shots_used  out  8  counted shots this round

## Operation
- Stage 1 registers pix_valid, mode, layer_en, layer_idx and is_cursor.
- Stage 2 reads the palette combinationally from the stage-1 indices, resolves the pixel colour and registers it into VGA_R/G/B and out_valid.
- Layer i is opaque when layer_en[i]=1 and palette[layer_idx[i]] != KEY_COLOR.
- Colour resolution for a stage-1 pixel, in priority order:
  - stage-1 valid=0: 000000
  - mode 00: TITLE_COLOR
  - mode 10 or 11: 000000
  - mode 01 with cursor=1: 000000 if flash_cnt != 0, else FFFFFF
  - mode 01 otherwise: the lowest-numbered opaque layer; if no layer is opaque, BG_COLOR
- Palette:
  - 2**IDX_W x 24 flops, all 000000 after reset.
  - A write commits at the clock edge. A stage-2 read in the same cycle returns the old value.
- Shot logic:
  - On shot with shots_used < MAX_SHOTS: shots_used increments and flash_cnt loads FLASH_FRAMES.
  - On shot with shots_used = MAX_SHOTS: both are ignored (saturate).
  - rearm clears shots_used to 0.
  - rearm and shot in the same cycle: rearm wins and the shot is dropped.
- Flash counter:
  - Decrements on frame_start while nonzero; holds at 0.
  - shot load and frame_start in the same cycle: the load wins, giving the full FLASH_FRAMES.

## Timing
- Latency is 2 cycles: inputs sampled at edge k appear on VGA_R/G/B and out_valid after edge k+1.
- There is no back-pressure. One pixel is accepted per cycle, including back-to-back.
- Cursor colour uses the flash_cnt value at stage 2. A shot at edge k affects the stage-2 pixel evaluated after edge k (the pixel sampled at edge k).
- Reset state, asynchronous and taking effect immediately:
  - VGA_R/G/B = 0, out_valid = 0, shots_used = 0
  - flash_cnt = 0, all pipeline registers = 0, palette = 0
- Reset asserted mid-frame discards in-flight pixels. After release, out_valid first rises 2 cycles after the first sampled pix_valid=1.
- A mode change takes effect per pixel. No frame alignment is applied.

## Test plan
- Reset release, write palette[3]=FF0000, then game mode with layer_en=0001, layer_idx[0]=3, pix_valid=1 -> RGB=FF,00,00 with out_valid=1 exactly 2 cycles later; RGB=0 before that.
- Write palette[5]=F442EE and palette[2]=00FF00; layer_en=0011, idx0=5, idx1=2 -> 00FF00. Then layer_en=0000 -> 0000F0.
- Mode 00 with any layers hit -> 00F0F0. Mode 10 with is_cursor=1 -> 000000.
- Pulse shot with FLASH_FRAMES=4 and hold is_cursor=1 -> cursor 000000 for 4 frame_start pulses, FFFFFF after the 4th. Fire 4 shots with MAX_SHOTS=3 -> shots_used=3 and the 4th shot does not reload the flash. Pulse rearm -> shots_used=0.
- Same-cycle cases:
  - pal_we to index 3 while a stage-2 pixel reads index 3 -> old colour for that pixel, new colour for the next.
  - shot with frame_start -> flash_cnt=FLASH_FRAMES.
  - shot with rearm -> shots_used=0.
- Assert Reset_n low mid-stream with pix_valid=1 -> outputs go 0 immediately. Release with pix_valid=1 -> out_valid rises 2 cycles later.

Source files
------------

// File: rtl/layer_compositor.sv
// Two-stage pixel compositor: layer hits resolve through a writable palette with a
// transparency key, then cursor flash and screen-mode fills produce registered VGA colour.
module layer_compositor #(
    parameter int          NUM_LAYERS   = 4,
    parameter int          IDX_W        = 4,
    parameter logic [23:0] KEY_COLOR    = 24'hF442EE,
    parameter logic [23:0] BG_COLOR     = 24'h0000F0,
    parameter logic [23:0] TITLE_COLOR  = 24'h00F0F0,
    parameter int          FLASH_FRAMES = 4,
    parameter int          MAX_SHOTS    = 3
) (
    input  logic                        Clk,
    input  logic                        Reset_n,
    input  logic                        pix_valid,
    input  logic                        frame_start,
    input  logic [1:0]                  mode,
    input  logic [NUM_LAYERS-1:0]       layer_en,
    input  logic [NUM_LAYERS*IDX_W-1:0] layer_idx,
    input  logic                        is_cursor,
    input  logic                        shot,
    input  logic                        rearm,
    input  logic                        pal_we,
    input  logic [IDX_W-1:0]            pal_waddr,
    input  logic [23:0]                 pal_wdata,
    output logic [7:0]                  VGA_R,
    output logic [7:0]                  VGA_G,
    output logic [7:0]                  VGA_B,
    output logic                        out_valid,
    output logic [7:0]                  shots_used
);
    localparam int DEPTH = 2**IDX_W;

    logic [23:0]                 pal_q [DEPTH];
    logic                        vld1_q;
    logic [1:0]                  mode1_q;
    logic [NUM_LAYERS-1:0]       en1_q;
    logic [NUM_LAYERS*IDX_W-1:0] idx1_q;
    logic                        cur1_q;
    logic [23:0]                 rgb_q, rgb_d;
    logic                        vld2_q;
    logic [7:0]                  shots_q, shots_d;
    logic [7:0]                  flash_q, flash_d;
    logic                        shot_take;

    // Palette lives in flops so it can be cleared by reset and read without latency.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) pal_q[i] <= '0;
        end else if (pal_we) begin
            pal_q[pal_waddr] <= pal_wdata;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vld1_q  <= 1'b0;
            mode1_q <= '0;
            en1_q   <= '0;
            idx1_q  <= '0;
            cur1_q  <= 1'b0;
        end else begin
            vld1_q  <= pix_valid;
            mode1_q <= mode;
            en1_q   <= layer_en;
            idx1_q  <= layer_idx;
            cur1_q  <= is_cursor;
        end
    end

    logic [NUM_LAYERS-1:0] opaque;
    logic [23:0]           layer_rgb [NUM_LAYERS];

    for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_layer
        assign layer_rgb[gi] = pal_q[idx1_q[gi*IDX_W +: IDX_W]];
        assign opaque[gi]    = en1_q[gi] && (layer_rgb[gi] != KEY_COLOR);
    end

    logic [23:0] layer_pick;

    // Scan from the lowest priority upward so the lowest-numbered opaque layer wins.
    always_comb begin
        layer_pick = BG_COLOR;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (opaque[i]) layer_pick = layer_rgb[i];
        end
    end

    always_comb begin
        rgb_d = 24'h000000;
        if (vld1_q) begin
            case (mode1_q)
                2'b00: rgb_d = TITLE_COLOR;
                2'b01: begin
                    if (cur1_q) rgb_d = (flash_q != 8'd0) ? 24'h000000 : 24'hFFFFFF;
                    else        rgb_d = layer_pick;
                end
                default: rgb_d = 24'h000000;
            endcase
        end
    end

    // Rearm takes precedence over a same-cycle shot; a saturated counter ignores shots.
    assign shot_take = shot && !rearm && (shots_q < 8'(MAX_SHOTS));

    always_comb begin
        shots_d = shots_q;
        flash_d = flash_q;
        if (rearm)          shots_d = 8'd0;
        else if (shot_take) shots_d = shots_q + 8'd1;
        if (shot_take)                            flash_d = 8'(FLASH_FRAMES);
        else if (frame_start && flash_q != 8'd0)  flash_d = flash_q - 8'd1;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rgb_q   <= '0;
            vld2_q  <= 1'b0;
            shots_q <= '0;
            flash_q <= '0;
        end else begin
            rgb_q   <= rgb_d;
            vld2_q  <= vld1_q;
            shots_q <= shots_d;
            flash_q <= flash_d;
        end
    end

    assign VGA_R      = rgb_q[23:16];
    assign VGA_G      = rgb_q[15:8];
    assign VGA_B      = rgb_q[7:0];
    assign out_valid  = vld2_q;
    assign shots_used = shots_q;
endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench: stimulus pushes expected colours into a queue; a negedge monitor
// pops and compares each valid output pixel.
module tb_layer_compositor;
    logic        Clk;
    logic        Reset_n;
    logic        pix_valid;
    logic        frame_start;
    logic [1:0]  mode;
    logic [3:0]  layer_en;
    logic [15:0] layer_idx;
    logic        is_cursor;
    logic        shot;
    logic        rearm;
    logic        pal_we;
    logic [3:0]  pal_waddr;
    logic [23:0] pal_wdata;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        out_valid;
    logic [7:0]  shots_used;

    int checks = 0;
    int errors = 0;
    logic [23:0] sb[$];

    layer_compositor dut (
        .Clk(Clk), .Reset_n(Reset_n), .pix_valid(pix_valid), .frame_start(frame_start),
        .mode(mode), .layer_en(layer_en), .layer_idx(layer_idx), .is_cursor(is_cursor),
        .shot(shot), .rearm(rearm), .pal_we(pal_we), .pal_waddr(pal_waddr),
        .pal_wdata(pal_wdata), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .out_valid(out_valid), .shots_used(shots_used)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every valid output pixel must match the oldest expected colour.
    always @(negedge Clk) begin
        logic [23:0] got;
        logic [23:0] req;
        got = {VGA_R, VGA_G, VGA_B};
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_pixel", {8'h0, got}, 32'hFFFF_FFFF);
            end else begin
                req = sb.pop_front();
                $display("pixel rgb=%h expected=%h", got, req);
                chk("pixel_rgb", {8'h0, got}, {8'h0, req});
            end
        end else begin
            chk("idle_rgb_zero", {7'h0, out_valid, got}, 32'h0);
        end
    end

    task automatic cycle();
        @(posedge Clk);
        #1;
        shot        = 1'b0;
        rearm       = 1'b0;
        frame_start = 1'b0;
        pal_we      = 1'b0;
        pix_valid   = 1'b0;
        is_cursor   = 1'b0;
        layer_en    = 4'h0;
    endtask

    task automatic pix(input logic [1:0] m, input logic [3:0] en, input logic [15:0] idx,
                       input logic cur, input logic [23:0] req);
        pix_valid = 1'b1;
        mode      = m;
        layer_en  = en;
        layer_idx = idx;
        is_cursor = cur;
        sb.push_back(req);
    endtask

    task automatic pal_write(input logic [3:0] a, input logic [23:0] d);
        pal_we    = 1'b1;
        pal_waddr = a;
        pal_wdata = d;
    endtask

    initial begin
        Reset_n = 1'b0; pix_valid = 0; frame_start = 0; mode = 2'b01; layer_en = 0;
        layer_idx = 0; is_cursor = 0; shot = 0; rearm = 0; pal_we = 0; pal_waddr = 0;
        pal_wdata = 0;
        repeat (3) @(posedge Clk);
        #1;
        chk("reset_rgb", {VGA_R, VGA_G, VGA_B}, 32'h0);
        chk("reset_valid", {31'h0, out_valid}, 32'h0);
        chk("reset_shots", {24'h0, shots_used}, 32'h0);
        Reset_n = 1'b1;
        cycle();

        // Basic layer lookup and two-cycle latency
        pal_write(4'd3, 24'hFF0000); cycle();
        pix(2'b01, 4'b0001, 16'h0003, 1'b0, 24'hFF0000); cycle();
        chk("latency_not_yet", {31'h0, out_valid}, 32'h0);
        cycle();
        chk("latency_valid", {31'h0, out_valid}, 32'h1);

        // Transparency key, priority, background
        pal_write(4'd5, 24'hF442EE); cycle();
        pal_write(4'd2, 24'h00FF00); cycle();
        pix(2'b01, 4'b0011, 16'h0025, 1'b0, 24'h00FF00); cycle();
        pix(2'b01, 4'b0000, 16'h0025, 1'b0, 24'h0000F0); cycle();
        pix(2'b01, 4'b0011, 16'h0023, 1'b0, 24'hFF0000); cycle();
        pix(2'b01, 4'b0011, 16'h0055, 1'b0, 24'h0000F0); cycle();

        // Screen modes and idle cursor
        pix(2'b00, 4'b1111, 16'h2223, 1'b0, 24'h00F0F0); cycle();
        pix(2'b10, 4'b0001, 16'h0003, 1'b1, 24'h000000); cycle();
        pix(2'b11, 4'b0001, 16'h0003, 1'b0, 24'h000000); cycle();
        pix(2'b01, 4'b0001, 16'h0003, 1'b1, 24'hFFFFFF); cycle();

        // Shot flash: black for FLASH_FRAMES frames, shot affects its own pixel
        shot = 1'b1;
        pix(2'b01, 4'b0001, 16'h0003, 1'b1, 24'h000000); cycle();
        chk("shots_after_1", {24'h0, shots_used}, 32'd1);
        for (int f = 1; f <= 4; f++) begin
            frame_start = 1'b1; cycle();
            pix(2'b01, 4'b0000, 16'h0000, 1'b1, (f < 4) ? 24'h000000 : 24'hFFFFFF); cycle();
        end

        // Saturation at MAX_SHOTS: the extra shot neither counts nor flashes
        shot = 1'b1; cycle();
        shot = 1'b1; cycle();
        chk("shots_after_3", {24'h0, shots_used}, 32'd3);
        pix(2'b01, 4'b0000, 16'h0000, 1'b1, 24'h000000); cycle();
        for (int f = 0; f < 4; f++) begin
            frame_start = 1'b1; cycle();
        end
        shot = 1'b1;
        pix(2'b01, 4'b0000, 16'h0000, 1'b1, 24'hFFFFFF); cycle();
        chk("shots_saturated", {24'h0, shots_used}, 32'd3);
        rearm = 1'b1; cycle();
        chk("shots_rearm", {24'h0, shots_used}, 32'd0);

        // Shot with frame_start: load wins, full flash length
        shot = 1'b1; frame_start = 1'b1; cycle();
        for (int f = 0; f < 3; f++) begin
            frame_start = 1'b1; cycle();
        end
        pix(2'b01, 4'b0000, 16'h0000, 1'b1, 24'h000000); cycle();
        frame_start = 1'b1; cycle();
        pix(2'b01, 4'b0000, 16'h0000, 1'b1, 24'hFFFFFF); cycle();
        chk("shots_frame_start", {24'h0, shots_used}, 32'd1);

        // Shot with rearm: shot dropped, no flash
        shot = 1'b1; rearm = 1'b1;
        pix(2'b01, 4'b0000, 16'h0000, 1'b1, 24'hFFFFFF); cycle();
        chk("shots_shot_rearm", {24'h0, shots_used}, 32'd0);

        // Palette write in the same cycle as a stage-2 read of that entry
        pix(2'b01, 4'b0001, 16'h0003, 1'b0, 24'hFF0000); cycle();
        pal_write(4'd3, 24'h0000AA);
        pix(2'b01, 4'b0001, 16'h0003, 1'b0, 24'h0000AA); cycle();
        pix(2'b01, 4'b0001, 16'h0003, 1'b0, 24'h0000AA); cycle();
        repeat (3) cycle();

        // Reset mid-stream discards in-flight pixels
        shot = 1'b1; cycle();
        pix(2'b00, 4'b0000, 16'h0000, 1'b0, 24'h00F0F0); cycle();
        pix(2'b00, 4'b0000, 16'h0000, 1'b0, 24'h00F0F0); cycle();
        pix(2'b00, 4'b0000, 16'h0000, 1'b0, 24'h00F0F0);
        chk("pre_reset_valid", {31'h0, out_valid}, 32'h1);
        #1 Reset_n = 1'b0;
        #1;
        chk("midreset_rgb", {VGA_R, VGA_G, VGA_B}, 32'h0);
        chk("midreset_valid", {31'h0, out_valid}, 32'h0);
        chk("midreset_shots", {24'h0, shots_used}, 32'h0);
        sb.delete();
        @(posedge Clk); #1;
        // Palette is cleared by reset, so layer 0 reads an opaque black entry
        pix(2'b01, 4'b0001, 16'h0003, 1'b0, 24'h000000);
        Reset_n = 1'b1;
        cycle();
        chk("post_reset_not_yet", {31'h0, out_valid}, 32'h0);
        pix(2'b00, 4'b0000, 16'h0000, 1'b0, 24'h00F0F0); cycle();
        chk("post_reset_valid", {31'h0, out_valid}, 32'h1);
        repeat (4) cycle();

        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
